// File: rtl/pc_unit.sv
// Program counter with boot/run/halt sequencing, trap and redirect steering.
// Misaligned redirects halt the fetch stream until a trap or reset.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     C_EXT        = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            inst_compressed,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            fetch_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] maddr_q, maddr_d;

  logic [XLEN-1:0] trap_aligned;
  logic            redirect_bad;
  logic [XLEN-1:0] pc_inc;

  always_comb begin
    if (C_EXT != 0) begin
      trap_aligned = {trap_target[XLEN-1:1], 1'b0};
      redirect_bad = redirect_target[0];
      pc_inc       = inst_compressed ? XLEN'(2) : XLEN'(4);
    end else begin
      trap_aligned = {trap_target[XLEN-1:2], 2'b00};
      redirect_bad = |redirect_target[1:0];
      pc_inc       = XLEN'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    maddr_d = maddr_q;
    if (reset) begin
      state_d = StBoot;
      pc_d    = RESET_VECTOR;
      maddr_d = '0;
    end else begin
      case (state_q)
        StBoot: state_d = StRun;
        StRun: begin
          if (trap_valid) begin
            pc_d = trap_aligned;
          end else if (redirect_valid) begin
            if (redirect_bad) begin
              state_d = StHalt;
              mis_d   = 1'b1;
              maddr_d = redirect_target;
            end else begin
              pc_d = redirect_target;
            end
          end else if (fetch_ready && !stall) begin
            pc_d = pc_q + pc_inc;  // wraps modulo 2^XLEN
          end
        end
        StHalt: begin
          // Only a trap (or reset) leaves HALT; redirects are dropped.
          if (trap_valid) begin
            state_d = StRun;
            pc_d    = trap_aligned;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    mis_q   <= mis_d;
    maddr_q <= maddr_d;
  end

  assign pc              = pc_q;
  assign pc_next         = pc_d;
  assign fetch_valid     = (state_q == StRun);
  assign misaligned      = mis_q;
  assign misaligned_addr = maddr_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-003 SHALL have parameter C_EXT, default 0; 1 enables 16-bit instruction alignment and +2 increments.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  pipeline stall; blocks sequential advance.
REQ-007 SHALL have port fetch_ready  input  1  fetch stage accepts the current pc.
REQ-008 SHALL have port inst_compressed  input  1  current instruction is 16-bit.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken.
REQ-010 SHALL have port redirect_target  input  XLEN  branch/jump destination.
REQ-011 SHALL have port trap_valid  input  1  trap or exception entry request.
REQ-012 SHALL have port trap_target  input  XLEN  trap handler address.
REQ-013 SHALL have port pc  output  XLEN  registered current PC.
REQ-014 SHALL have port pc_next  output  XLEN  combinational value pc takes at the next edge.
REQ-015 SHALL have port fetch_valid  output  1  pc is a valid fetch request.
REQ-016 SHALL have port misaligned  output  1  one-cycle pulse: misaligned redirect rejected.
REQ-017 SHALL have port misaligned_addr  output  XLEN  registered offending redirect target.

Function
REQ-018 SHALL implement states BOOT, RUN, HALT; fetch_valid = 1 only in RUN.
REQ-019 BOOT SHALL last exactly one cycle, ignore all inputs, then go to RUN with pc unchanged.
REQ-020 Priority per edge SHALL be: reset > trap_valid > redirect_valid > sequential advance > hold.
REQ-021 trap_valid in RUN or HALT SHALL load pc with trap_target, low bits forced to 0 (bits [1:0] if C_EXT=0, bit 0 if C_EXT=1), and go to RUN, regardless of stall or fetch_ready.
REQ-022 Target alignment rule: C_EXT=0 requires target[1:0]==0; C_EXT=1 requires target[0]==0.
REQ-023 redirect_valid in RUN with aligned target SHALL load pc with redirect_target at the next edge, regardless of stall or fetch_ready.
REQ-024 redirect_valid in RUN with misaligned target SHALL hold pc, latch misaligned_addr, pulse misaligned for one cycle, and go to HALT.
REQ-025 redirect_valid in HALT SHALL be ignored; HALT exits only on trap_valid or reset.
REQ-026 Sequential advance in RUN SHALL occur only when fetch_valid && fetch_ready && !stall: pc += 2 if C_EXT=1 and inst_compressed, else pc += 4.
REQ-027 inst_compressed SHALL be ignored when C_EXT=0.
REQ-028 pc arithmetic SHALL wrap modulo 2^XLEN with no flag.
REQ-029 pc_next SHALL equal the value pc takes at the next edge under REQ-020, including RESET_VECTOR while reset is high.

Reset
REQ-030 reset SHALL set pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misaligned=0, misaligned_addr=0.
REQ-031 reset asserted in any state SHALL override trap, redirect and advance in that cycle.

Verification
REQ-032 Reset with RESET_VECTOR=32'hDEADBEEC -> pc=32'hDEADBEEC, fetch_valid=0 for one cycle, then 1.
REQ-033 RUN at pc=32'h100, fetch_ready=1, stall toggled 1,0,0 -> pc 32'h100,32'h100,32'h104,32'h108.
REQ-034 C_EXT=1, pc=32'h200, inst_compressed=1, fetch_ready=1 -> pc=32'h202; redirect 32'h301 -> misaligned pulse, misaligned_addr=32'h301, HALT, fetch_valid=0.
REQ-035 Same-cycle trap_valid (32'h80000003) and redirect_valid (32'h400) -> pc=32'h80000000 (C_EXT=0), state RUN.
REQ-036 pc=32'hFFFFFFFC advance -> pc=32'h00000000; reset asserted during HALT -> pc=RESET_VECTOR, state BOOT.
